elevator_scheduler: RTL and testbench
=====================================

ELEVATOR_SCHEDULER -- requirements
Module: elevator_scheduler

Interface
REQ-001 SHALL have parameter STEP_TICKS, default 4: number of tick strobes needed to travel one floor (legal range 2..15).
REQ-002 SHALL have parameter MAX_PEND, default 4: saturation limit of each floor's pending-request count (legal range 1..7).
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous, active-low.
REQ-005 SHALL have port tick  input  1: one-cycle step strobe from the slow clock divider.
REQ-006 SHALL have port req_valid  input  1: one-cycle request pulse from the decoded keypad.
REQ-007 SHALL have port req_floor  input  2: requested floor; 1..3 are valid, 0 is ignored.
REQ-008 SHALL have port cur_floor  output  2: current floor, 1..3.
REQ-009 SHALL have port dir  output  2: 00 stay, 01 up, 10 down.
REQ-010 SHALL have port phase  output  2: travel animation step, 0..3; equals step count mod 4.
REQ-011 SHALL have ports pend1, pend2, pend3  output  3 each: pending-request count per floor, 0..MAX_PEND.
REQ-012 SHALL have port arrive  output  1: one-cycle pulse on the cycle cur_floor changes.

Function
REQ-013 SHALL implement states IDLE, UP, DOWN and SERVE, registered, with combinational next-state logic.
REQ-014 SHALL treat a request as accepted when req_valid=1 and req_floor is 1..3, on any cycle and in any state; the accepted floor's count increments by 1 and saturates at MAX_PEND.
REQ-015 SHALL ignore req_floor=0, and requests arriving while rst=0.
REQ-016 SHALL evaluate state transitions, phase, service and movement only on cycles with tick=1; on all other cycles only request capture occurs.
REQ-017 IDLE on tick: if pend[cur_floor]>0, go to SERVE; otherwise, if a floor other than cur_floor is pending, go to UP or DOWN per REQ-024 or REQ-025; otherwise stay IDLE.
REQ-018 UP or DOWN on tick: step counter +1. When the counter reaches STEP_TICKS-1, on that tick cur_floor changes by ±1, the counter clears and arrive pulses.
REQ-019 On arrival: if the new floor's count >0, go to SERVE. Otherwise continue in the same direction if a floor further in that direction is pending. Otherwise re-evaluate as IDLE on the next tick.
REQ-020 SERVE on tick: decrement pend[cur_floor] by 1; if the result is 0, go to IDLE.
REQ-021 When a capture and a service decrement hit the same floor in the same cycle, the net count SHALL be unchanged, including at MAX_PEND.
REQ-022 cur_floor SHALL never leave 1..3: UP from floor 3 or DOWN from floor 1 is illegal; next-state logic SHALL prevent it.
REQ-023 dir SHALL be 01 in UP, 10 in DOWN, 00 in IDLE/SERVE; phase SHALL be 0 outside UP/DOWN; all outputs SHALL be registered.

Configuration
REQ-024 With ELEV_SCAN_EN defined, direction choice SHALL be SCAN: keep the last travel direction while any floor in that direction is pending, otherwise reverse; the last direction resets to up.
REQ-025 Without ELEV_SCAN_EN, direction choice SHALL be nearest pending floor; on a distance tie (at floor 2 with floors 1 and 3 pending) go up.

Reset
REQ-026 rst=0 at a clock edge SHALL force state IDLE, cur_floor=1, dir=00, phase=0, step counter 0, all pend counts 0, arrive=0, last direction up, regardless of the state, including mid-travel.
REQ-027 The first tick after rst returns to 1 SHALL be processed normally.

Verification
REQ-028 Reset, then request floor 3, then 8 ticks -> dir=01; arrive pulses at tick 4 (cur_floor 2) and tick 8 (cur_floor 3); state SERVE.
REQ-029 At floor 1, 6 requests for floor 2 -> pend2=4 (saturated); after travel and 4 SERVE ticks -> pend2=0, state IDLE.
REQ-030 In SERVE at floor 2 with pend2=4: request floor 2 on the same cycle as a tick -> pend2 stays 4.
REQ-031 At floor 2 after an up move, with floors 1 and 3 pending: SCAN build goes up to floor 3 first; non-SCAN build also goes up (tie rule). After a down move, SCAN goes to floor 1 first.
REQ-032 Assert rst=0 at phase=2 mid-travel -> next cycle cur_floor=1, dir=00, phase=0, all pend counts 0.
REQ-033 req_floor=0 with req_valid=1, and requests arriving on non-tick cycles: the first leaves all counts unchanged; the second are counted, with no state change until the next tick.

Source files
------------

// File: rtl/elevator_scheduler_if.sv
// Keypad/divider inputs and status outputs of the elevator scheduler.
// The master side drives tick and requests; the slave side is the scheduler.
interface elevator_scheduler_if;
  logic       tick;
  logic       req_valid;
  logic [1:0] req_floor;
  logic [1:0] cur_floor;
  logic [1:0] dir;
  logic [1:0] phase;
  logic [2:0] pend1;
  logic [2:0] pend2;
  logic [2:0] pend3;
  logic       arrive;

  modport master (
    output tick, req_valid, req_floor,
    input  cur_floor, dir, phase, pend1, pend2, pend3, arrive
  );

  modport slave (
    input  tick, req_valid, req_floor,
    output cur_floor, dir, phase, pend1, pend2, pend3, arrive
  );
endinterface

// File: rtl/elevator_scheduler.sv
// Three-floor elevator scheduler: per-floor pending counts, tick-paced travel and service.
// Define ELEV_SCAN_EN for SCAN direction choice; default is nearest-pending with ties going up.
module elevator_scheduler #(
  parameter int unsigned STEP_TICKS = 4,
  parameter int unsigned MAX_PEND   = 4
) (
  input logic                 clk,
  input logic                 rst,
  elevator_scheduler_if.slave elev_io
);

  typedef enum logic [1:0] {StIdle, StUp, StDown, StServe} state_e;

  localparam logic [3:0] StepLast = 4'(STEP_TICKS - 1);
  localparam logic [2:0] PendMax  = 3'(MAX_PEND);

  state_e     state_q, state_d;
  logic [1:0] floor_q, floor_d;
  logic [1:0] dir_q, dir_d;
  logic [3:0] step_q, step_d;
  logic [2:0] pend_q [3];
  logic [2:0] pend_d [3];
  logic       arrive_q, arrive_d;
`ifdef ELEV_SCAN_EN
  logic       last_up_q, last_up_d;
`endif

  logic [2:0] cap, svc;
  logic [1:0] nxt_floor;
  logic       above, below, here, new_here, further, served_out;
  logic       go_up, go_dn;

  // Decisions look at counts before this cycle's capture; the count update merges both.
  always_comb begin
    cap        = '0;
    svc        = '0;
    above      = 1'b0;
    below      = 1'b0;
    here       = 1'b0;
    new_here   = 1'b0;
    further    = 1'b0;
    served_out = 1'b0;
    nxt_floor  = (state_q == StDown) ? floor_q - 2'd1 : floor_q + 2'd1;
    for (int i = 0; i < 3; i++) begin
      cap[i] = elev_io.req_valid && (elev_io.req_floor == 2'(i + 1));
      svc[i] = elev_io.tick && (state_q == StServe) && (floor_q == 2'(i + 1)) &&
               (pend_q[i] != '0);
      if (cap[i] && !svc[i]) begin
        pend_d[i] = (pend_q[i] >= PendMax) ? PendMax : pend_q[i] + 3'd1;
      end else if (svc[i] && !cap[i]) begin
        pend_d[i] = pend_q[i] - 3'd1;
      end else begin
        pend_d[i] = pend_q[i];
      end
      if (pend_q[i] != '0) begin
        if (2'(i + 1) > floor_q)   above    = 1'b1;
        if (2'(i + 1) < floor_q)   below    = 1'b1;
        if (2'(i + 1) == floor_q)  here     = 1'b1;
        if (2'(i + 1) == nxt_floor) new_here = 1'b1;
        if ((state_q == StUp) && (2'(i + 1) > nxt_floor))   further = 1'b1;
        if ((state_q == StDown) && (2'(i + 1) < nxt_floor)) further = 1'b1;
      end
      if ((floor_q == 2'(i + 1)) && (pend_d[i] == '0)) served_out = 1'b1;
    end
  end

`ifdef ELEV_SCAN_EN
  assign go_up = above && (last_up_q || !below);
`else
  assign go_up = above;
`endif
  assign go_dn = below && !go_up;

  always_comb begin
    state_d   = state_q;
    floor_d   = floor_q;
    step_d    = step_q;
    arrive_d  = 1'b0;
`ifdef ELEV_SCAN_EN
    last_up_d = last_up_q;
`endif
    if (elev_io.tick) begin
      case (state_q)
        StIdle: begin
          if (here) begin
            state_d = StServe;
          end else if (go_up) begin
            state_d = StUp;
            step_d  = 4'd1;
`ifdef ELEV_SCAN_EN
            last_up_d = 1'b1;
`endif
          end else if (go_dn) begin
            state_d = StDown;
            step_d  = 4'd1;
`ifdef ELEV_SCAN_EN
            last_up_d = 1'b0;
`endif
          end
        end
        StUp, StDown: begin
          if (((state_q == StUp) && (floor_q == 2'd3)) ||
              ((state_q == StDown) && (floor_q == 2'd1))) begin
            state_d = StIdle;
            step_d  = '0;
          end else if (step_q >= StepLast) begin
            floor_d  = nxt_floor;
            step_d   = '0;
            arrive_d = 1'b1;
            if (new_here) begin
              state_d = StServe;
            end else if (!further) begin
              state_d = StIdle;
            end
          end else begin
            step_d = step_q + 4'd1;
          end
        end
        StServe: begin
          if (served_out) state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
          step_d  = '0;
        end
      endcase
    end
    case (state_d)
      StUp:    dir_d = 2'b01;
      StDown:  dir_d = 2'b10;
      default: dir_d = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      floor_q   <= 2'd1;
      dir_q     <= 2'b00;
      step_q    <= '0;
      pend_q    <= '{3'd0, 3'd0, 3'd0};
      arrive_q  <= 1'b0;
`ifdef ELEV_SCAN_EN
      last_up_q <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      dir_q     <= dir_d;
      step_q    <= step_d;
      pend_q    <= pend_d;
      arrive_q  <= arrive_d;
`ifdef ELEV_SCAN_EN
      last_up_q <= last_up_d;
`endif
    end
  end

  assign elev_io.cur_floor = floor_q;
  assign elev_io.dir       = dir_q;
  assign elev_io.phase     = step_q[1:0];
  assign elev_io.pend1     = pend_q[0];
  assign elev_io.pend2     = pend_q[1];
  assign elev_io.pend3     = pend_q[2];
  assign elev_io.arrive    = arrive_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Bench for elevator_scheduler: directed scenarios plus random traffic against a behavioural model.
module tb_elevator_scheduler;
  localparam int STEP = 4;
  localparam int MAXP = 4;

  logic clk;
  logic rst;
  elevator_scheduler_if bus ();

  elevator_scheduler #(.STEP_TICKS(STEP), .MAX_PEND(MAXP)) dut (
    .clk     (clk),
    .rst     (rst),
    .elev_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: floor number, motion (+1/-1/0), serving flag, ticks into current floor hop.
  int m_floor, m_move, m_cnt, m_last;
  bit m_serve, m_arrive;
  int m_pend [1:3];

  task automatic m_update(input bit r, input bit t, input bit v, input logic [1:0] f);
    int  p [1:3];
    int  n, d, dec_floor;
    bit  up_p, dn_p, fur;
    if (!r) begin
      m_floor = 1; m_move = 0; m_cnt = 0; m_last = 1; m_serve = 0; m_arrive = 0;
      for (int k = 1; k <= 3; k++) m_pend[k] = 0;
      return;
    end
    p = m_pend;
    m_arrive = 0;
    dec_floor = 0;
    if (t) begin
      up_p = 0; dn_p = 0;
      for (int k = 1; k <= 3; k++) if (p[k] > 0) begin
        if (k > m_floor) up_p = 1;
        if (k < m_floor) dn_p = 1;
      end
      if (m_serve) begin
        dec_floor = m_floor;
      end else if (m_move == 0) begin
        if (p[m_floor] > 0) m_serve = 1;
        else begin
`ifdef ELEV_SCAN_EN
          if (m_last == 1) d = up_p ? 1 : (dn_p ? -1 : 0);
          else             d = dn_p ? -1 : (up_p ? 1 : 0);
`else
          d = up_p ? 1 : (dn_p ? -1 : 0);
`endif
          if (d != 0) begin m_move = d; m_cnt = 1; m_last = d; end
        end
      end else if (m_cnt == STEP - 1) begin
        m_floor += m_move; m_cnt = 0; m_arrive = 1;
        if (p[m_floor] > 0) begin
          m_serve = 1; m_move = 0;
        end else begin
          fur = 0;
          for (int k = 1; k <= 3; k++) if (p[k] > 0 && (k - m_floor) * m_move > 0) fur = 1;
          if (!fur) m_move = 0;
        end
      end else begin
        m_cnt++;
      end
    end
    for (int k = 1; k <= 3; k++) begin
      n = p[k] + int'(v && (int'(f) == k)) - int'(dec_floor == k);
      m_pend[k] = (n > MAXP) ? MAXP : n;
    end
    if (dec_floor != 0 && m_pend[m_floor] == 0) m_serve = 0;
  endtask

  task automatic drive(input bit r, input bit t, input bit v, input logic [1:0] f);
    rst = r; bus.tick = t; bus.req_valid = v; bus.req_floor = f;
    @(posedge clk);
    m_update(r, t, v, f);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) drive(1, 1, 0, 0);
  endtask

  task automatic test_reset();
    drive(0, 1, 1, 3);
    drive(0, 1, 1, 2);
    n_vec++;
    if ({bus.cur_floor, bus.dir, bus.phase, bus.pend1, bus.pend2, bus.pend3, bus.arrive} !==
        {2'd1, 2'd0, 2'd0, 3'd0, 3'd0, 3'd0, 1'b0}) begin
      n_err++;
      $display("FAIL reset: floor=%0d dir=%0d phase=%0d pend=%0d/%0d/%0d arrive=%0d, want 1 0 0 0/0/0 0",
               bus.cur_floor, bus.dir, bus.phase, bus.pend1, bus.pend2, bus.pend3, bus.arrive);
    end
  endtask

  task automatic test_travel();
    logic [1:0] e_fl, e_dir, e_ph;
    logic       e_arr;
    do_reset();
    drive(1, 0, 1, 3);
    for (int i = 1; i <= 8; i++) begin
      drive(1, 1, 0, 0);
      e_arr = (i == 4 || i == 8);
      e_fl  = (i < 4) ? 2'd1 : (i < 8) ? 2'd2 : 2'd3;
      e_dir = (i == 8) ? 2'd0 : 2'd1;
      e_ph  = 2'(i % 4);
      n_vec++;
      if ({bus.arrive, bus.cur_floor, bus.dir, bus.phase} !== {e_arr, e_fl, e_dir, e_ph}) begin
        n_err++;
        $display("FAIL travel tick %0d: arrive=%0d floor=%0d dir=%0d phase=%0d, want %0d %0d %0d %0d",
                 i, bus.arrive, bus.cur_floor, bus.dir, bus.phase, e_arr, e_fl, e_dir, e_ph);
      end
    end
    ticks(1);
    n_vec++;
    if ({bus.pend3, bus.dir, bus.arrive} !== {3'd0, 2'd0, 1'b0}) begin
      n_err++;
      $display("FAIL travel serve: pend3=%0d dir=%0d arrive=%0d, want 0 0 0",
               bus.pend3, bus.dir, bus.arrive);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 6; i++) drive(1, 0, 1, 2);
    n_vec++;
    if (bus.pend2 !== 3'd4) begin
      n_err++; $display("FAIL saturate count: pend2=%0d, want 4", bus.pend2);
    end
    ticks(4);
    n_vec++;
    if ({bus.cur_floor, bus.arrive, bus.pend2, bus.dir} !== {2'd2, 1'b1, 3'd4, 2'd0}) begin
      n_err++;
      $display("FAIL saturate arrive: floor=%0d arrive=%0d pend2=%0d dir=%0d, want 2 1 4 0",
               bus.cur_floor, bus.arrive, bus.pend2, bus.dir);
    end
    ticks(4);
    n_vec++;
    if ({bus.pend2, bus.dir} !== {3'd0, 2'd0}) begin
      n_err++; $display("FAIL saturate drain: pend2=%0d dir=%0d, want 0 0", bus.pend2, bus.dir);
    end
    ticks(1);
    n_vec++;
    if ({bus.cur_floor, bus.dir, bus.phase} !== {2'd2, 2'd0, 2'd0}) begin
      n_err++;
      $display("FAIL saturate idle: floor=%0d dir=%0d phase=%0d, want 2 0 0",
               bus.cur_floor, bus.dir, bus.phase);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    for (int i = 0; i < 4; i++) drive(1, 0, 1, 2);
    ticks(4);
    drive(1, 1, 1, 2);
    n_vec++;
    if (bus.pend2 !== 3'd4) begin
      n_err++; $display("FAIL same_cycle net: pend2=%0d, want 4", bus.pend2);
    end
    ticks(1);
    n_vec++;
    if (bus.pend2 !== 3'd3) begin
      n_err++; $display("FAIL same_cycle dec: pend2=%0d, want 3", bus.pend2);
    end
  endtask

  task automatic test_direction();
    logic [1:0] e_dir;
    do_reset();
    drive(1, 0, 1, 2);
    ticks(4);
    drive(1, 0, 1, 1);
    drive(1, 0, 1, 3);
    ticks(2);
    n_vec++;
    if ({bus.cur_floor, bus.dir} !== {2'd2, 2'd1}) begin
      n_err++;
      $display("FAIL dir after up: floor=%0d dir=%0d, want 2 1", bus.cur_floor, bus.dir);
    end
    do_reset();
    drive(1, 0, 1, 3);
    ticks(9);
    drive(1, 0, 1, 2);
    ticks(4);
    n_vec++;
    if ({bus.cur_floor, bus.arrive} !== {2'd2, 1'b1}) begin
      n_err++;
      $display("FAIL dir down arrive: floor=%0d arrive=%0d, want 2 1", bus.cur_floor, bus.arrive);
    end
    drive(1, 0, 1, 1);
    drive(1, 0, 1, 3);
    ticks(2);
`ifdef ELEV_SCAN_EN
    e_dir = 2'd2;
`else
    e_dir = 2'd1;
`endif
    n_vec++;
    if (bus.dir !== e_dir) begin
      n_err++; $display("FAIL dir after down: dir=%0d, want %0d", bus.dir, e_dir);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1, 0, 1, 3);
    drive(1, 0, 1, 2);
    ticks(2);
    n_vec++;
    if ({bus.dir, bus.phase} !== {2'd1, 2'd2}) begin
      n_err++; $display("FAIL mid setup: dir=%0d phase=%0d, want 1 2", bus.dir, bus.phase);
    end
    drive(0, 1, 1, 2);
    n_vec++;
    if ({bus.cur_floor, bus.dir, bus.phase, bus.pend1, bus.pend2, bus.pend3, bus.arrive} !==
        {2'd1, 2'd0, 2'd0, 3'd0, 3'd0, 3'd0, 1'b0}) begin
      n_err++;
      $display("FAIL mid reset: floor=%0d dir=%0d phase=%0d pend=%0d/%0d/%0d, want 1 0 0 0/0/0",
               bus.cur_floor, bus.dir, bus.phase, bus.pend1, bus.pend2, bus.pend3);
    end
    drive(1, 0, 1, 3);
    ticks(1);
    n_vec++;
    if ({bus.dir, bus.phase, bus.pend3} !== {2'd1, 2'd1, 3'd1}) begin
      n_err++;
      $display("FAIL first tick: dir=%0d phase=%0d pend3=%0d, want 1 1 1",
               bus.dir, bus.phase, bus.pend3);
    end
  endtask

  task automatic test_ignore();
    do_reset();
    drive(1, 1, 1, 0);
    n_vec++;
    if ({bus.pend1, bus.pend2, bus.pend3, bus.dir} !== {3'd0, 3'd0, 3'd0, 2'd0}) begin
      n_err++;
      $display("FAIL floor0: pend=%0d/%0d/%0d dir=%0d, want 0/0/0 0",
               bus.pend1, bus.pend2, bus.pend3, bus.dir);
    end
    drive(1, 0, 1, 2);
    drive(1, 0, 1, 3);
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    n_vec++;
    if ({bus.pend2, bus.pend3, bus.cur_floor, bus.dir, bus.phase} !==
        {3'd1, 3'd1, 2'd1, 2'd0, 2'd0}) begin
      n_err++;
      $display("FAIL no-tick capture: pend2=%0d pend3=%0d floor=%0d dir=%0d phase=%0d, want 1 1 1 0 0",
               bus.pend2, bus.pend3, bus.cur_floor, bus.dir, bus.phase);
    end
  endtask

  task automatic test_random();
    logic [14:0] got, exp;
    logic [1:0]  e_dir;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 199) != 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)));
      e_dir = (m_move == 1) ? 2'd1 : (m_move == -1) ? 2'd2 : 2'd0;
      exp = {2'(m_floor), e_dir, 2'(m_cnt % 4), 3'(m_pend[1]), 3'(m_pend[2]), 3'(m_pend[3]),
             m_arrive};
      got = {bus.cur_floor, bus.dir, bus.phase, bus.pend1, bus.pend2, bus.pend3, bus.arrive};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL random cycle %0d: got %b want %b (floor,dir,phase,pend1,pend2,pend3,arrive)",
                 i, got, exp);
      end
    end
  endtask

  initial begin
    rst = 1'b0; bus.tick = 1'b0; bus.req_valid = 1'b0; bus.req_floor = 2'd0;
    m_update(0, 0, 0, 0);
    test_reset();
    test_travel();
    test_saturate();
    test_same_cycle();
    test_direction();
    test_reset_mid();
    test_ignore();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
